// File: rtl/column_unpacker.sv
// column_unpacker
//   Rebuilds two 32-bit AES column words from a stream of four 16-bit half-rows.
//   Each half-row is {col0 byte, col1 byte} for one state row. Row 0 lands in
//   the MSB byte of each column word. A one-group hold buffer absorbs
//   back-pressure so the input side can keep streaming.
//
//   Optional feature: define UNPACK_SYNC_EN to enable in_first framing checks
//   and resynchronisation. Without it, in_first is ignored and sync_err is 0.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush_i             synchronous abort of partial, held and output groups
//   in_valid/in_ready   half-row handshake
//   in_first            row-0 marker (UNPACK_SYNC_EN only)
//   halfRow             {col0 byte, col1 byte} of the current row
//   out_valid/out_ready column-word handshake
//   ALUoperand0/1       column 0 / column 1 words
//   sync_err            sticky framing error
module column_unpacker #(
   parameter int unsigned BYTE_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush_i,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_first,
   input  logic [2*BYTE_W-1:0] halfRow,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [4*BYTE_W-1:0] ALUoperand0,
   output logic [4*BYTE_W-1:0] ALUoperand1,
   output logic                sync_err
);

   typedef enum logic [0:0] {StFill, StHold} state_e;

   state_e              state_q;
   logic [1:0]          row_cnt_q;
   logic [BYTE_W-1:0]   fill_hi_q [3];
   logic [BYTE_W-1:0]   fill_lo_q [3];
   logic [4*BYTE_W-1:0] hold0_q, hold1_q;
   logic [4*BYTE_W-1:0] op0_q, op1_q;
   logic                out_valid_q;
   logic                sync_err_q;

   logic                slot_free;
   logic                accept;
   logic                grp_done;
   logic                frame_err;
   logic [1:0]          wr_row;
   logic [4*BYTE_W-1:0] grp0, grp1;

   assign slot_free = !out_valid_q || out_ready;
   // Gated by rst_n so in_ready drops the moment reset is asserted.
   assign in_ready  = rst_n && (state_q == StFill) && !flush_i;
   assign accept    = in_valid && in_ready;

`ifdef UNPACK_SYNC_EN
   // A misplaced in_first restarts the group with this half-row as row 0.
   assign wr_row    = (accept && in_first && (row_cnt_q != 2'd0)) ? 2'd0 : row_cnt_q;
   assign frame_err = accept && (in_first != (row_cnt_q == 2'd0));
`else
   logic unused_in_first;
   assign unused_in_first = in_first;
   assign wr_row          = row_cnt_q;
   assign frame_err       = 1'b0;
`endif

   assign grp_done = accept && (wr_row == 2'd3);

   // Row 3 bypasses the fill buffer and is taken straight from the input.
   assign grp0 = {fill_hi_q[0], fill_hi_q[1], fill_hi_q[2], halfRow[2*BYTE_W-1:BYTE_W]};
   assign grp1 = {fill_lo_q[0], fill_lo_q[1], fill_lo_q[2], halfRow[BYTE_W-1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StFill;
         row_cnt_q   <= 2'd0;
         hold0_q     <= '0;
         hold1_q     <= '0;
         op0_q       <= '0;
         op1_q       <= '0;
         out_valid_q <= 1'b0;
         sync_err_q  <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            fill_hi_q[i] <= '0;
            fill_lo_q[i] <= '0;
         end
      end else begin
         // accept is already 0 during flush, so flush never masks this.
         if (frame_err) sync_err_q <= 1'b1;

         if (flush_i) begin
            state_q     <= StFill;
            row_cnt_q   <= 2'd0;
            out_valid_q <= 1'b0;
         end else begin
            if (accept) begin
               row_cnt_q <= wr_row + 2'd1;
               for (int i = 0; i < 3; i++) begin
                  if (wr_row == 2'(i)) begin
                     fill_hi_q[i] <= halfRow[2*BYTE_W-1:BYTE_W];
                     fill_lo_q[i] <= halfRow[BYTE_W-1:0];
                  end
               end
            end

            unique case (state_q)
               StHold: begin
                  if (slot_free) begin
                     op0_q       <= hold0_q;
                     op1_q       <= hold1_q;
                     out_valid_q <= 1'b1;
                     state_q     <= StFill;
                  end
               end
               StFill: begin
                  if (grp_done) begin
                     if (slot_free) begin
                        op0_q       <= grp0;
                        op1_q       <= grp1;
                        out_valid_q <= 1'b1;
                     end else begin
                        hold0_q <= grp0;
                        hold1_q <= grp1;
                        state_q <= StHold;
                     end
                  end else if (out_ready) begin
                     out_valid_q <= 1'b0;
                  end
               end
               default: state_q <= StFill;
            endcase
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign ALUoperand0 = op0_q;
   assign ALUoperand1 = op1_q;
   assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_column_unpacker.sv
// Directed self-checking bench for column_unpacker (BYTE_W = 8).
module tb_column_unpacker;

   logic        clk;
   logic        rst_n;
   logic        flush_i;
   logic        in_valid;
   logic        in_ready;
   logic        in_first;
   logic [15:0] halfRow;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUoperand0;
   logic [31:0] ALUoperand1;
   logic        sync_err;

   int n_checks = 0;
   int n_fail   = 0;

   column_unpacker #(.BYTE_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush_i),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_first    (in_first),
      .halfRow     (halfRow),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .ALUoperand0 (ALUoperand0),
      .ALUoperand1 (ALUoperand1),
      .sync_err    (sync_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] v, input logic first);
      in_valid = 1'b1;
      halfRow  = v;
      in_first = first;
      tick();
      in_valid = 1'b0;
      in_first = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      n_checks++;
      if (ALUoperand0 !== 32'h0 || ALUoperand1 !== 32'h0) begin
         n_fail++; $display("FAIL reset_operands: got %h %h want 0 0", ALUoperand0, ALUoperand1);
      end
      n_checks++;
      if (sync_err !== 1'b0) begin n_fail++; $display("FAIL reset_sync_err: got %b want 0", sync_err); end
      #10 rst_n = 1'b1;
      tick();
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      send(16'h0011, 1'b1);
      send(16'h2233, 1'b0);
      send(16'h4455, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
      send(16'h6677, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", out_valid); end
      n_checks++;
      if (ALUoperand0 !== 32'h00224466) begin n_fail++; $display("FAIL basic_op0: got %h want 00224466", ALUoperand0); end
      n_checks++;
      if (ALUoperand1 !== 32'h11335577) begin n_fail++; $display("FAIL basic_op1: got %h want 11335577", ALUoperand1); end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_consumed: got %b want 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  b;
      logic [31:0] e0, e1;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         int g, r;
         g = i / 4;
         r = i % 4;
         b = 8'(8'h10 * (g + 1));
         in_valid = 1'b1;
         in_first = (r == 0);
         halfRow  = {b + 8'(r), b + 8'(r) + 8'h80};
         n_checks++;
         if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
         tick();
         if (r == 3) begin
            e0 = {b, b + 8'd1, b + 8'd2, b + 8'd3};
            e1 = e0 ^ 32'h80808080;
            n_checks++;
            if (out_valid !== 1'b1 || ALUoperand0 !== e0 || ALUoperand1 !== e1) begin
               n_fail++;
               $display("FAIL b2b_group[%0d]: got v=%b %h %h want v=1 %h %h",
                        g, out_valid, ALUoperand0, ALUoperand1, e0, e1);
            end
         end else begin
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_gap[%0d]: got %b want 0", i, out_valid); end
         end
      end
      in_valid = 1'b0;
      in_first = 1'b0;
      tick();
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      send(16'hA1B1, 1'b1);
      send(16'hA2B2, 1'b0);
      send(16'hA3B3, 1'b0);
      send(16'hA4B4, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || ALUoperand0 !== 32'hA1A2A3A4 || ALUoperand1 !== 32'hB1B2B3B4) begin
         n_fail++; $display("FAIL stall_g1: got v=%b %h %h want v=1 a1a2a3a4 b1b2b3b4", out_valid, ALUoperand0, ALUoperand1);
      end
      send(16'hC1D1, 1'b1);
      send(16'hC2D2, 1'b0);
      send(16'hC3D3, 1'b0);
      send(16'hC4D4, 1'b0);
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_low: got %b want 0", in_ready); end
      tick();
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || ALUoperand0 !== 32'hA1A2A3A4 || ALUoperand1 !== 32'hB1B2B3B4) begin
         n_fail++; $display("FAIL stall_hold: got v=%b %h %h want v=1 a1a2a3a4 b1b2b3b4", out_valid, ALUoperand0, ALUoperand1);
      end
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || ALUoperand0 !== 32'hC1C2C3C4 || ALUoperand1 !== 32'hD1D2D3D4) begin
         n_fail++; $display("FAIL stall_g2: got v=%b %h %h want v=1 c1c2c3c4 d1d2d3d4", out_valid, ALUoperand0, ALUoperand1);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_in_ready_back: got %b want 1", in_ready); end
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drained: got %b want 0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b1;
      send(16'h0102, 1'b1);
      send(16'h0304, 1'b0);
      flush_i = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
      tick();
      flush_i = 1'b0;
      send(16'h5161, 1'b1);
      send(16'h5262, 1'b0);
      send(16'h5363, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_partial_valid: got %b want 0", out_valid); end
      send(16'h5464, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || ALUoperand0 !== 32'h51525354 || ALUoperand1 !== 32'h61626364) begin
         n_fail++; $display("FAIL flush_new_group: got v=%b %h %h want v=1 51525354 61626364", out_valid, ALUoperand0, ALUoperand1);
      end
      out_ready = 1'b0;
      flush_i   = 1'b1;
      tick();
      flush_i   = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || ALUoperand0 !== 32'h51525354) begin
         n_fail++; $display("FAIL flush_output: got v=%b %h want v=0 51525354", out_valid, ALUoperand0);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      send(16'h1121, 1'b1);
      send(16'h1222, 1'b0);
      send(16'h1323, 1'b0);
      send(16'h1424, 1'b0);
      send(16'h7788, 1'b1);
      send(16'h99AA, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || sync_err !== 1'b0 || ALUoperand0 !== 32'h0) begin
         n_fail++; $display("FAIL async_reset: got v=%b rdy=%b err=%b op0=%h want 0 0 0 0",
                            out_valid, in_ready, sync_err, ALUoperand0);
      end
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      send(16'h3141, 1'b1);
      send(16'h3242, 1'b0);
      send(16'h3343, 1'b0);
      send(16'h3444, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || ALUoperand0 !== 32'h31323334 || ALUoperand1 !== 32'h41424344) begin
         n_fail++; $display("FAIL async_reset_regroup: got v=%b %h %h want v=1 31323334 41424344",
                            out_valid, ALUoperand0, ALUoperand1);
      end
      tick();
   endtask

   task automatic test_sync();
      out_ready = 1'b1;
      n_checks++;
      if (sync_err !== 1'b0) begin n_fail++; $display("FAIL sync_clean: got %b want 0", sync_err); end
`ifdef UNPACK_SYNC_EN
      send(16'h0101, 1'b1);
      send(16'h0202, 1'b0);
      send(16'h0303, 1'b1);
      n_checks++;
      if (sync_err !== 1'b1) begin n_fail++; $display("FAIL sync_err_set: got %b want 1", sync_err); end
      send(16'h0404, 1'b0);
      send(16'h0505, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sync_early_valid: got %b want 0", out_valid); end
      send(16'h0606, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || ALUoperand0 !== 32'h03040506 || ALUoperand1 !== 32'h03040506) begin
         n_fail++; $display("FAIL sync_regroup: got v=%b %h %h want v=1 03040506 03040506", out_valid, ALUoperand0, ALUoperand1);
      end
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      n_checks++;
      if (sync_err !== 1'b1) begin n_fail++; $display("FAIL sync_err_sticky: got %b want 1", sync_err); end
`else
      send(16'h0101, 1'b1);
      send(16'h0202, 1'b0);
      send(16'h0303, 1'b1);
      send(16'h0404, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || ALUoperand0 !== 32'h01020304 || ALUoperand1 !== 32'h01020304) begin
         n_fail++; $display("FAIL first_ignored: got v=%b %h %h want v=1 01020304 01020304", out_valid, ALUoperand0, ALUoperand1);
      end
      n_checks++;
      if (sync_err !== 1'b0) begin n_fail++; $display("FAIL sync_err_tied: got %b want 0", sync_err); end
`endif
      tick();
   endtask

   initial begin
      rst_n     = 1'b0;
      flush_i   = 1'b0;
      in_valid  = 1'b0;
      in_first  = 1'b0;
      halfRow   = 16'h0;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_stall();
      test_flush();
      test_async_reset();
      test_sync();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/column_unpacker.md
Name: column_unpacker

Overview:
- Inverse of the half-row packing stage on the AES vector datapath.
- Accepts a stream of 16-bit half-rows, four per group (state rows 0..3). Each half-row carries one byte from each of two columns.
- Rebuilds the two 32-bit column words that feed ALU lanes 0 and 1.
- Sits between the vector register read port and the ALU operand latches. Uses valid/ready handshakes on both sides and buffers one complete group so the input can keep streaming.

Parameters:
BYTE_W, 8, byte lane width. Half-row = 2*BYTE_W bits; column word = 4*BYTE_W bits. Row count is fixed at 4.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush_i  input  1  synchronous abort; discards partial group and any buffered/output group
in_valid  input  1  half-row valid
in_ready  output  1  unpacker can accept a half-row this cycle
in_first  input  1  marks row 0 of a group (used only with UNPACK_SYNC_EN)
halfRow  input  2*BYTE_W  {col0 byte, col1 byte} of current row
out_valid  output  1  column words valid
out_ready  input  1  consumer accepts column words
ALUoperand0  output  4*BYTE_W  column 0 word
ALUoperand1  output  4*BYTE_W  column 1 word
sync_err  output  1  sticky framing error (0 when UNPACK_SYNC_EN is absent)

Behaviour:
- Reset (rst_n low, asynchronous):
  - row_cnt=0; fill buffer empty; buf_full=0.
  - out_valid=0; ALUoperand0/1=0; sync_err=0.
  - in_ready deasserts combinationally while in reset.
- Input accept: in_valid && in_ready.
  - Row r = row_cnt is written into the fill buffer: high byte -> col0 byte r, low byte -> col1 byte r.
  - row_cnt then increments modulo 4.
- Assembly:
  - ALUoperand0 = {r0[hi], r1[hi], r2[hi], r3[hi]}.
  - ALUoperand1 = {r0[lo], r1[lo], r2[lo], r3[lo]}.
  - Row 0 occupies the MSB byte.
- Output slot is free when !out_valid || out_ready (combinational).
- Accepting row 3 while the slot is free:
  - The group loads directly into the output registers at that edge.
  - out_valid=1 the next cycle; latency is 1 cycle from the 4th accept.
  - row_cnt wraps to 0.
- Accepting row 3 while the slot is busy:
  - buf_full=1 and in_ready=0.
  - When the slot frees, the buffer transfers to the output at that edge, buf_full clears, and in_ready reasserts the next cycle.
- in_ready = !buf_full && !flush_i.
- Sustained throughput is 1 half-row/cycle with out_ready held high: one group per 4 cycles, no bubbles.
- Output hold: while out_valid && !out_ready, ALUoperand0/1 and out_valid stay stable.
- Simultaneous events at the same edge:
  - out_ready accepts a group while row 3 arrives: the new group replaces it; out_valid stays 1.
- flush_i:
  - Highest priority after reset.
  - Next edge: row_cnt=0, buf_full=0, out_valid=0. Operand registers keep their old values.
  - Any handshake in the flush cycle is ignored.
  - sync_err is not cleared by flush_i.
- FSM:
  - FILL (buf_full=0): row_cnt counts 0..3.
  - HOLD (buf_full=1): waits for the output slot.
  - FILL -> HOLD on row-3 accept with slot busy.
  - HOLD -> FILL on slot free.
  - Any state -> FILL on flush_i.

Optional Feature:
- Macro UNPACK_SYNC_EN.
- Defined:
  - in_first on an accepted half-row with row_cnt != 0 sets sync_err (sticky until reset).
  - The partial group is discarded, and that half-row becomes row 0 (row_cnt -> 1).
  - in_first low with row_cnt == 0 also sets sync_err, but the row is kept.
- Undefined: in_first is ignored and sync_err is tied 0.

Test Plan:
- Reset, then half-rows 0x0011, 0x2233, 0x4455, 0x6677 on consecutive cycles with out_ready=1 -> out_valid one cycle after the 4th; ALUoperand0=0x00224466, ALUoperand1=0x11335577.
- 12 back-to-back half-rows with out_ready=1 -> in_ready never drops; three groups; out_valid pulses every 4 cycles in correct order.
- out_ready=0 across two full groups -> group 1 held stable; group 2 captured; in_ready=0 after the 8th accept. Raise out_ready -> group 1 then group 2 emitted; in_ready high again.
- Two half-rows sent, then flush_i for 1 cycle, then 4 new half-rows -> output contains only the new 4; no out_valid from the partial group.
- rst_n dropped mid-group (asynchronously, between edges) -> out_valid, in_ready, row_cnt and sync_err read 0 immediately.
- UNPACK_SYNC_EN: in_first=1 on the 3rd half-row -> sync_err=1; next 4 accepts (including that one) form a correct group.
